mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 146 ++++++++++++++
 tb/tb_mem_access_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store initiator for a word-only data memory
module mem_access_unit #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state, next_state;
  logic        accept, req_err;
  logic [1:0]  off_q, size_q;
  logic        signed_q, write_q, resp_err_q;
  logic [31:0] wdata_q, word_q, mem_addr_q, resp_rdata_q;
  logic [4:0]  lane_sh;
  logic [31:0] lane_mask, lane_word, load_val, merged;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  // Shift that brings the addressed lane down to bit 0 of the word.
  always_comb begin
    lane_sh   = 5'd0;
    lane_mask = 32'hFFFF_FFFF;
    case (size_q)
      2'b00: begin
        lane_sh   = BIG_ENDIAN ? {~off_q, 3'b000} : {off_q, 3'b000};
        lane_mask = 32'h0000_00FF << lane_sh;
      end
      2'b01: begin
        lane_sh   = BIG_ENDIAN ? {~off_q[1], 4'b0000} : {off_q[1], 4'b0000};
        lane_mask = 32'h0000_FFFF << lane_sh;
      end
      default: begin
        lane_sh   = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign lane_word = mem_rdata >> lane_sh;
  assign merged    = (word_q & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);

  always_comb begin
    load_val = lane_word;
    case (size_q)
      2'b00:   load_val = {{24{signed_q & lane_word[7]}}, lane_word[7:0]};
      2'b01:   load_val = {{16{signed_q & lane_word[15]}}, lane_word[15:0]};
      default: load_val = lane_word;
    endcase
  end

  always_comb begin
    next_state = state;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = 32'd0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)
            next_state = RESP;
          else if (req_write && req_size == 2'b10)
            next_state = WRITE;
          else
            next_state = READ;
        end
      end
      READ:  next_state = write_q ? WRITE : RESP;
      WRITE: begin
        next_state = RESP;
        mem_we     = !reset;
        mem_wdata  = merged;
      end
      RESP: begin
        next_state = IDLE;
        resp_valid = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      off_q        <= 2'd0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= 32'd0;
      word_q       <= 32'd0;
      mem_addr_q   <= 32'd0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        off_q        <= req_addr[1:0];
        size_q       <= req_size;
        signed_q     <= req_signed;
        write_q      <= req_write;
        wdata_q      <= req_wdata;
        resp_err_q   <= req_err;
        resp_rdata_q <= 32'd0;
        // Errored requests never reach memory, so the address bus keeps its last value.
        if (!req_err)
          mem_addr_q <= {req_addr[31:2], 2'b00};
      end
      if (state == READ) begin
        word_q <= mem_rdata;
        if (!write_q)
          resp_rdata_q <= load_val;
      end
    end
  end

  assign mem_addr   = mem_addr_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed vector bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  mem_access_unit #(.BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(string nm, logic wr, logic [1:0] sz, logic sg, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] rd, logic er, int lat, int we,
                              logic [31:0] ewd);
    vec_t v;
    v.name = nm; v.wr = wr; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd;
    v.exp_rdata = rd; v.exp_err = er; v.exp_lat = lat; v.exp_we = we; v.exp_wdata = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat, we_cnt;
    logic addr_bad, ready_bad;
    logic [31:0] wd_seen;
    @(negedge clk);
    req_valid = 1'b1; req_write = v.wr; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata;
    chk({v.name, " ready_before"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hA5A5_A5A5;
    lat = 1; we_cnt = 0; addr_bad = 1'b0; ready_bad = 1'b0; wd_seen = 32'd0;
    while (!resp_valid && lat < 10) begin
      if (req_ready) ready_bad = 1'b1;
      if (mem_addr !== {v.addr[31:2], 2'b00}) addr_bad = 1'b1;
      if (mem_we) begin
        we_cnt++;
        wd_seen = mem_wdata;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk({v.name, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({v.name, " latency"}, lat, v.exp_lat);
    chk({v.name, " rdata"}, resp_rdata, v.exp_rdata);
    chk({v.name, " err"}, {31'd0, resp_err}, {31'd0, v.exp_err});
    chk({v.name, " we_cycles"}, we_cnt, v.exp_we);
    if (v.exp_we != 0) chk({v.name, " mem_wdata"}, wd_seen, v.exp_wdata);
    if (!v.exp_err) chk({v.name, " mem_addr_bad"}, {31'd0, addr_bad}, 32'd0);
    chk({v.name, " ready_busy"}, {31'd0, ready_bad | req_ready}, 32'd0);
    @(posedge clk); #1;
    chk({v.name, " resp_one_cycle"}, {31'd0, resp_valid}, 32'd0);
    chk({v.name, " ready_after"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[4] = 32'h8899_AABB;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

    vecs[0]  = mk("lb_11",   0, 2'b00, 1, 32'h11, 0, 32'hFFFF_FF99, 0, 2, 0, 0);
    vecs[1]  = mk("lbu_13",  0, 2'b00, 0, 32'h13, 0, 32'h0000_00BB, 0, 2, 0, 0);
    vecs[2]  = mk("lh_12",   0, 2'b01, 1, 32'h12, 0, 32'hFFFF_AABB, 0, 2, 0, 0);
    vecs[3]  = mk("lhu_10",  0, 2'b01, 0, 32'h10, 0, 32'h0000_8899, 0, 2, 0, 0);
    vecs[4]  = mk("lw_10",   0, 2'b10, 0, 32'h10, 0, 32'h8899_AABB, 0, 2, 0, 0);
    vecs[5]  = mk("sb_10",   1, 2'b00, 0, 32'h10, 32'h1122_3344, 0, 0, 3, 1, 32'h4499_AABB);
    vecs[6]  = mk("sw_20",   1, 2'b10, 0, 32'h20, 32'hDEAD_BEEF, 0, 0, 2, 1, 32'hDEAD_BEEF);
    vecs[7]  = mk("sh_11",   1, 2'b01, 0, 32'h11, 32'h0000_7777, 0, 1, 1, 0, 0);
    vecs[8]  = mk("size3",   0, 2'b11, 1, 32'h00, 0, 0, 1, 1, 0, 0);
    vecs[9]  = mk("lw_20",   0, 2'b10, 0, 32'h20, 0, 32'hDEAD_BEEF, 0, 2, 0, 0);
    vecs[10] = mk("lw_21",   0, 2'b10, 0, 32'h21, 0, 0, 1, 1, 0, 0);
    vecs[11] = mk("sh_12",   1, 2'b01, 0, 32'h12, 32'h1234_CAFE, 0, 0, 3, 1, 32'h4499_CAFE);
    vecs[12] = mk("lb_12",   0, 2'b00, 1, 32'h12, 0, 32'hFFFF_FFCA, 0, 2, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", {31'd0, req_ready}, 32'd0);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst rdata", resp_rdata, 32'd0);
    chk("rst err", {31'd0, resp_err}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post rst ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i]);
      if (i == 5) chk("mem10 after sb", mem[4], 32'h4499_AABB);
      if (i == 6) chk("mem20 after sw", mem[8], 32'hDEAD_BEEF);
      if (i == 8) chk("mem10 after errs", mem[4], 32'h4499_AABB);
    end
    chk("mem10 after sh", mem[4], 32'h4499_CAFE);

    // Reset during the WRITE cycle of a sub-word store drops it entirely.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_0055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rstw mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rstw ready", {31'd0, req_ready}, 32'd1);
    chk("rstw mem_addr", mem_addr, 32'd0);
    chk("rstw resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rstw no resp", {31'd0, resp_valid | mem_we}, 32'd0);
    end
    chk("rstw mem10", mem[4], 32'h4499_CAFE);

    // A request presented together with reset is not accepted.
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    #1;
    chk("rstreq ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("rstreq no resp", {31'd0, resp_valid}, 32'd0);
    chk("rstreq idle", {31'd0, req_ready}, 32'd1);

    // Back-to-back sw then lw to the same word with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h30;
    req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_write = 1'b0; req_wdata = 32'd0;
    chk("b2b ready write", {31'd0, req_ready}, 32'd0);
    chk("b2b we", {31'd0, mem_we}, 32'd1);
    @(posedge clk); #1;
    chk("b2b resp1", {31'd0, resp_valid}, 32'd1);
    chk("b2b ready resp", {31'd0, req_ready}, 32'd0);
    chk("b2b mem30", mem[12], 32'h1234_5678);
    @(posedge clk); #1;
    chk("b2b ready idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b accepted", {31'd0, req_ready}, 32'd0);
    chk("b2b read addr", mem_addr, 32'h30);
    @(posedge clk); #1;
    chk("b2b resp2", {31'd0, resp_valid}, 32'd1);
    chk("b2b rdata", resp_rdata, 32'h1234_5678);
    chk("b2b err", {31'd0, resp_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
